// File: rtl/adsr_envelope_pkg.sv
// Shared synth definitions for the wave chain: envelope state encodings and level limits.
package adsr_envelope_pkg;

    typedef enum logic [2:0] {
        EnvIdle    = 3'd0,
        EnvAttack  = 3'd1,
        EnvDecay   = 3'd2,
        EnvSustain = 3'd3,
        EnvRelease = 3'd4
    } env_state_e;

    // Full-scale envelope level for a given level width.
    function automatic int unsigned env_max(input int unsigned bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

endpackage

// File: rtl/env_prescaler.sv
// Envelope tick counter: counts sample strobes and emits a step strobe every (rate+1) strobes.
module env_prescaler #(
    parameter int unsigned RATE_BITS = 16
) (
    input  logic                 main_clk,
    input  logic                 reset,
    input  logic                 sample_en,
    input  logic                 clear,
    input  logic [RATE_BITS-1:0] rate,
    output logic                 step
);

    logic [RATE_BITS-1:0] count_q, count_d;

    always_comb begin
        // >= rather than == so a rate lowered mid-count cannot strand the counter
        step    = sample_en && (count_q >= rate);
        count_d = count_q;
        if (clear || step) begin
            count_d = '0;
        end else if (sample_en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge main_clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/adsr_envelope.sv
// ADSR envelope generator: gate-driven level FSM plus per-sample envelope scaling of the voice.
module adsr_envelope
    import adsr_envelope_pkg::*;
#(
    parameter int unsigned OUTPUT_BITS = 12,
    parameter int unsigned ENV_BITS    = 8,
    parameter int unsigned RATE_BITS   = 16
) (
    input  logic                          main_clk,
    input  logic                          reset,
    input  logic                          sample_en,
    input  logic                          gate,
    input  logic [RATE_BITS-1:0]          attack_rate,
    input  logic [RATE_BITS-1:0]          decay_rate,
    input  logic [RATE_BITS-1:0]          release_rate,
    input  logic [ENV_BITS-1:0]           sustain_level,
    input  logic signed [OUTPUT_BITS-1:0] din,
    output logic signed [OUTPUT_BITS-1:0] dout,
    output logic                          dout_valid,
    output logic [ENV_BITS-1:0]           env_level,
    output logic [2:0]                    env_state
);

    localparam int unsigned ProdBits = OUTPUT_BITS + ENV_BITS + 1;
    localparam logic [ENV_BITS-1:0] EnvMax = ENV_BITS'(env_max(ENV_BITS));

    env_state_e                    state_q, state_d;
    logic [ENV_BITS-1:0]           level_q, level_d;
    logic [ENV_BITS-1:0]           level_inc, level_dec;
    logic                          gate_q;
    logic                          gate_rise, gate_fall;
    logic [RATE_BITS-1:0]          active_rate;
    logic                          step;
    logic                          state_change;
    logic signed [ProdBits-1:0]    din_ext, level_ext, product;
    logic signed [OUTPUT_BITS-1:0] dout_q, dout_d;
    logic                          dout_valid_q;
    logic                          unused_prod;

    assign gate_rise = gate & ~gate_q;
    assign gate_fall = ~gate & gate_q;
    assign level_inc = level_q + 1'b1;
    assign level_dec = level_q - 1'b1;

    always_comb begin
        unique case (state_q)
            EnvAttack:  active_rate = attack_rate;
            EnvDecay:   active_rate = decay_rate;
            EnvRelease: active_rate = release_rate;
            default:    active_rate = '0;
        endcase
    end

    assign state_change = (state_d != state_q);

    env_prescaler #(
        .RATE_BITS (RATE_BITS)
    ) u_prescaler (
        .main_clk  (main_clk),
        .reset     (reset),
        .sample_en (sample_en),
        .clear     (state_change),
        .rate      (active_rate),
        .step      (step)
    );

    // Transitions take priority over steps; a target reached by a step moves state on that edge.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        unique case (state_q)
            EnvIdle: begin
                level_d = '0;
                if (gate_rise) state_d = EnvAttack;
            end
            EnvAttack: begin
                if (gate_fall) begin
                    state_d = EnvRelease;
                end else if (level_q == EnvMax) begin
                    state_d = EnvDecay;
                end else if (step) begin
                    level_d = level_inc;
                    if (level_inc == EnvMax) state_d = EnvDecay;
                end
            end
            EnvDecay: begin
                if (gate_fall) begin
                    state_d = EnvRelease;
                end else if (level_q <= sustain_level) begin
                    state_d = EnvSustain;
                end else if (step) begin
                    level_d = level_dec;
                    if (level_dec <= sustain_level) state_d = EnvSustain;
                end
            end
            EnvSustain: begin
                if (gate_fall) begin
                    state_d = EnvRelease;
                end else begin
                    level_d = sustain_level;
                end
            end
            EnvRelease: begin
                if (gate_rise) begin
                    state_d = EnvAttack;
                end else if (level_q == '0) begin
                    state_d = EnvIdle;
                end else if (step) begin
                    level_d = level_dec;
                    if (level_dec == '0) state_d = EnvIdle;
                end
            end
            default: begin
                state_d = EnvIdle;
                level_d = '0;
            end
        endcase
    end

    // Scale with the registered (pre-step) level; arithmetic shift floors toward -inf.
    assign din_ext   = ProdBits'(din);
    assign level_ext = ProdBits'({1'b0, level_q});
    assign product   = din_ext * level_ext;
    assign dout_d    = sample_en ? product[ENV_BITS +: OUTPUT_BITS] : dout_q;
    assign unused_prod = ^{product[ENV_BITS-1:0], product[ProdBits-1]};

    always_ff @(posedge main_clk or posedge reset) begin
        if (reset) begin
            state_q      <= EnvIdle;
            level_q      <= '0;
            gate_q       <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            gate_q       <= gate;
            dout_q       <= dout_d;
            dout_valid_q <= sample_en;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign env_level  = level_q;
    assign env_state  = state_q;

endmodule

// File: tb/tb_adsr_envelope.sv
// Self-checking bench for adsr_envelope: strobe-counting reference model plus directed literal checks.
module tb_adsr_envelope;

    logic               main_clk = 1'b0;
    logic               reset;
    logic               sample_en;
    logic               gate;
    logic [15:0]        attack_rate, decay_rate, release_rate;
    logic [7:0]         sustain_level;
    logic signed [11:0] din;
    logic signed [11:0] dout;
    logic               dout_valid;
    logic [7:0]         env_level;
    logic [2:0]         env_state;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    // Reference model state (phase numbers follow the exposed encoding)
    int m_state   = 0;
    int m_level   = 0;
    int m_strobes = 0;
    int m_dout    = 0;
    bit m_valid   = 1'b0;
    bit m_gate    = 1'b0;

    always #5 main_clk = ~main_clk;

    adsr_envelope dut (
        .main_clk      (main_clk),
        .reset         (reset),
        .sample_en     (sample_en),
        .gate          (gate),
        .attack_rate   (attack_rate),
        .decay_rate    (decay_rate),
        .release_rate  (release_rate),
        .sustain_level (sustain_level),
        .din           (din),
        .dout          (dout),
        .dout_valid    (dout_valid),
        .env_level     (env_level),
        .env_state     (env_state)
    );

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a phase lasts until its target; a step happens on every (rate+1)-th strobe of the phase.
    initial begin
        forever begin
            @(posedge main_clk or posedge reset);
            if (reset) begin
                m_state = 0; m_level = 0; m_strobes = 0; m_dout = 0; m_valid = 0; m_gate = 0;
            end else begin
                int ns, nl, rate;
                bit rise, fall, stp;
                rise = gate && !m_gate;
                fall = !gate && m_gate;
                rate = (m_state == 1) ? int'(attack_rate) :
                       (m_state == 2) ? int'(decay_rate) :
                       (m_state == 4) ? int'(release_rate) : 0;
                stp  = sample_en && (((m_strobes + 1) % (rate + 1)) == 0);
                ns = m_state;
                nl = m_level;
                if (m_state == 0) begin
                    nl = 0;
                    if (rise) ns = 1;
                end else if (m_state != 4 && fall) begin
                    ns = 4;
                end else if (m_state == 1) begin
                    if (stp && m_level < 255) nl = m_level + 1;
                    if (nl == 255) ns = 2;
                end else if (m_state == 2) begin
                    if (stp && m_level > int'(sustain_level)) nl = m_level - 1;
                    if (nl <= int'(sustain_level)) ns = 3;
                end else if (m_state == 3) begin
                    nl = sustain_level;
                end else begin
                    if (rise) ns = 1;
                    else begin
                        if (stp && m_level > 0) nl = m_level - 1;
                        if (nl == 0) ns = 0;
                    end
                end
                if (sample_en) m_dout = (int'(din) * m_level) >>> 8;
                m_valid   = sample_en;
                m_strobes = (ns != m_state) ? 0 : (sample_en ? m_strobes + 1 : m_strobes);
                m_state   = ns;
                m_level   = nl;
                m_gate    = gate;
            end
        end
    end

    initial begin
        forever begin
            @(negedge main_clk);
            if (cmp_on && !reset) begin
                check("cyc_env_state", env_state, m_state);
                check("cyc_env_level", env_level, m_level);
                check("cyc_dout", dout, m_dout);
                check("cyc_dout_valid", dout_valid, m_valid);
            end
        end
    end

    task automatic tick();
        @(posedge main_clk);
        @(negedge main_clk);
    endtask

    // n strobes, each preceded by gap idle cycles; leaves sample_en high
    task automatic strobes(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            sample_en = 1'b0;
            repeat (gap) tick();
            sample_en = 1'b1;
            tick();
        end
    endtask

    initial begin
        reset = 1'b1; gate = 1'b0; sample_en = 1'b0;
        attack_rate = 16'd0; decay_rate = 16'd1; release_rate = 16'd0;
        sustain_level = 8'd128; din = 12'sd2047;
        repeat (3) @(negedge main_clk);
        check("rst_state", env_state, 0);
        check("rst_level", env_level, 0);
        check("rst_dout", dout, 0);
        check("rst_valid", dout_valid, 0);

        // Attack at rate 0, then decay at rate 1 to sustain 128
        cmp_on = 1'b1;
        reset = 1'b0; gate = 1'b1;
        tick();
        check("attack_entry", env_state, 1);
        strobes(254, 0);
        check("attack_254", env_level, 254);
        check("attack_254_state", env_state, 1);
        strobes(1, 0);
        check("attack_255", env_level, 255);
        check("attack_to_decay", env_state, 2);
        strobes(1, 0);
        check("dout_2047x255", dout, 2039);
        check("dout_valid_hi", dout_valid, 1);
        strobes(252, 0);
        check("decay_129", env_level, 129);
        check("decay_129_state", env_state, 2);
        strobes(1, 0);
        check("decay_128", env_level, 128);
        check("decay_to_sustain", env_state, 3);
        din = -12'sd2048;
        strobes(1, 0);
        check("dout_m2048x128", dout, -1024);
        sustain_level = 8'd100;
        strobes(1, 0);
        check("sustain_track", env_level, 100);
        sample_en = 1'b0;
        tick();
        check("dout_valid_lo", dout_valid, 0);
        check("dout_hold", dout, -1024);

        // Release from sustain with gapped strobes
        gate = 1'b0; din = 12'sd1000;
        strobes(1, 0);
        check("release_from_sus", env_state, 4);
        check("release_from_sus_lvl", env_level, 100);
        strobes(100, 1);
        check("release_idle", env_state, 0);
        check("release_idle_lvl", env_level, 0);

        // New note into decay, then asynchronous reset between edges
        gate = 1'b1; decay_rate = 16'd0; sustain_level = 8'd128; din = 12'sd2047;
        strobes(256, 0);
        strobes(5, 0);
        check("decay_fast", env_level, 250);
        #2 reset = 1'b1;
        #1;
        check("async_rst_state", env_state, 0);
        check("async_rst_level", env_level, 0);
        check("async_rst_dout", dout, 0);
        check("async_rst_valid", dout_valid, 0);
        tick();
        tick();

        // Gate held through reset registers as a rise; release at rate 3 from 60
        release_rate = 16'd3;
        reset = 1'b0;
        tick();
        check("gate_held_rise", env_state, 1);
        strobes(60, 0);
        check("attack_60", env_level, 60);
        gate = 1'b0;
        strobes(1, 0);
        check("release_60_state", env_state, 4);
        check("release_60_level", env_level, 60);
        strobes(239, 0);
        check("release_1", env_level, 1);
        check("release_1_state", env_state, 4);
        strobes(1, 0);
        check("release_done_lvl", env_level, 0);
        check("release_done_state", env_state, 0);

        // Retrigger during release continues from the current level
        gate = 1'b1; release_rate = 16'd0;
        strobes(1, 0);
        strobes(40, 0);
        check("attack_40", env_level, 40);
        gate = 1'b0;
        strobes(1, 0);
        strobes(10, 1);
        check("release_30", env_level, 30);
        gate = 1'b1;
        strobes(1, 0);
        check("retrig_state", env_state, 1);
        check("retrig_level", env_level, 30);
        strobes(1, 0);
        check("retrig_next", env_level, 31);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adsr_envelope.md
ADSR_ENVELOPE -- requirements
Module: adsr_envelope

Interface
REQ-001 Parameter OUTPUT_BITS, default 12, SHALL set the signed sample width of din/dout.
REQ-002 Parameter ENV_BITS, default 8, SHALL set the unsigned envelope level width; ENV_MAX = 2**ENV_BITS-1.
REQ-003 Parameter RATE_BITS, default 16, SHALL set the width of the attack/decay/release rate inputs.
REQ-004 Port main_clk  in  1  SHALL be the single system clock; all logic is posedge main_clk.
REQ-005 Port reset  in  1  SHALL be the asynchronous, active-high reset.
REQ-006 Port sample_en  in  1  SHALL be a one-cycle sample strobe; it marks each sample and each envelope tick.
REQ-007 Port gate  in  1  SHALL be the note gate (high = key held).
REQ-008 Ports attack_rate, decay_rate, release_rate  in  RATE_BITS  SHALL each give the number of extra ticks between envelope steps.
REQ-009 Port sustain_level  in  ENV_BITS  SHALL be the sustain target level.
REQ-010 Port din  in  OUTPUT_BITS signed  SHALL be the raw voice sample from the wave generator.
REQ-011 Port dout  out  OUTPUT_BITS signed  SHALL be the envelope-scaled sample.
REQ-012 Port dout_valid  out  1  SHALL pulse for one cycle when dout updates.
REQ-013 Port env_level  out  ENV_BITS  SHALL expose the current envelope level.
REQ-014 Port env_state  out  3  SHALL expose the FSM state (IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4).

Function
REQ-015 Gate SHALL be registered once internally; gate_rise = gate & ~gate_q, gate_fall = ~gate & gate_q.
REQ-016 A prescaler SHALL advance only on sample_en; when prescaler equals the active rate, one step SHALL occur and prescaler SHALL clear on that same cycle; rate 0 SHALL step on every sample_en.
REQ-017 Prescaler SHALL clear on every state transition.
REQ-018 IDLE: env_level held at 0; gate_rise -> ATTACK.
REQ-019 ATTACK: each step increments env_level by 1 (attack_rate); on reaching ENV_MAX -> DECAY; no wrap past ENV_MAX.
REQ-020 DECAY: each step decrements by 1 (decay_rate) while env_level > sustain_level; when env_level <= sustain_level -> SUSTAIN.
REQ-021 SUSTAIN: env_level SHALL load sustain_level each cycle (tracks live changes).
REQ-022 gate_fall in ATTACK, DECAY or SUSTAIN SHALL go to RELEASE from the current level, no jump.
REQ-023 RELEASE: each step decrements by 1 (release_rate); at 0 -> IDLE; gate_rise in RELEASE -> ATTACK from current level (retrigger, no reset to 0).
REQ-024 gate_rise and gate_fall are mutually exclusive; gate_rise in ATTACK/DECAY/SUSTAIN SHALL be ignored.
REQ-025 On the cycle after sample_en, dout SHALL equal (din * {1'b0,env_level}) >>> ENV_BITS using the env_level present at sample_en, computed at OUTPUT_BITS+ENV_BITS+1 signed width, truncated toward negative infinity; dout_valid SHALL be high that cycle only.
REQ-026 dout SHALL hold between updates; latency sample_en -> dout_valid is exactly 1 cycle.
REQ-027 A step and a sample_en in the same cycle SHALL scale with the pre-step level.

Reset
REQ-028 Reset SHALL force env_state=IDLE, env_level=0, dout=0, dout_valid=0, prescaler=0, gate_q=0, immediately and asynchronously.
REQ-029 Reset mid-note SHALL abandon the note; a gate still high after reset release SHALL register as gate_rise on the first clock.

Structure
REQ-030 State encodings and ENV_MAX derivation SHALL live in a shared synth package used by wave-chain blocks.
REQ-031 One sub-module, env_prescaler (tick counter + step strobe), SHALL be instantiated; the multiply SHALL be inline.

Verification
REQ-032 Reset, gate=1, attack_rate=0, sample_en every cycle -> env_level 1,2,...,255 over 255 strobes, then env_state=DECAY.
REQ-033 decay_rate=1, sustain_level=128 -> env_level steps every 2nd strobe from 255 down to 128, env_state=SUSTAIN; sustain_level changed to 100 -> env_level=100 next cycle.
REQ-034 din=2047, env_level=255, sample_en -> next cycle dout=2039, dout_valid=1; din=-2048, env_level=128 -> dout=-1024.
REQ-035 gate falls at env_level=60 in ATTACK, release_rate=3 -> RELEASE from 60, step every 4th strobe, IDLE at 0 after 240 strobes.
REQ-036 gate re-raised in RELEASE at env_level=30 -> ATTACK continuing from 30 (next step 31).
REQ-037 reset asserted mid-DECAY without clock edge -> all outputs 0, env_state=IDLE immediately.
